regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register pending-write scoreboard, optional same-cycle write-to-read bypass, and a debug read port. It replaces the fixed 32x32, 2-read/1-write register file in the core datapath. It serves superscalar or multi-writeback pipelines, where two results can retire per cycle and issue logic must know which registers still have an outstanding producer.

## Interface
- `XLEN`, default 32: register width in bits.
- `NREGS`, default 32: number of registers. Must be a power of two, at least 2.
- `AW`, default `$clog2(NREGS)`: address width. Derived; never overridden.
- `NRD`, default 2: number of architectural read ports, 1..4.
- `BYPASS`, default 1: 1 means a read returns same-cycle write data; 0 means a read returns only stored data.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset. Clears all registers and all busy bits.
- `rd_addr` in `NRD*AW`: packed read addresses. Port k occupies `[k*AW +: AW]`.
- `rd_data` out `NRD*XLEN`: packed read data, combinational.
- `rd_busy` out `NRD`: a 1 means a write to `rd_addr[k]` is still pending.
- `wr0_en`, `wr1_en` in 1 each: write enables.
- `wr0_addr`, `wr1_addr` in `AW` each: write addresses.
- `wr0_data`, `wr1_data` in `XLEN` each: write data.
- `iss_en` in 1: marks `iss_addr` busy (a producer has been issued).
- `iss_addr` in `AW`: destination register of the issued producer.
- `dbg_addr` in `AW`: debug read address.
- `dbg_data` out `XLEN`: stored value at `dbg_addr`. Never bypassed.
- `busy_vec` out `NREGS`: the full scoreboard, registered.

## Operation
- Register 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - A read of address 0 returns 0, including on `dbg_data`.
  - `busy[0]` is constant 0. `iss_en` with `iss_addr`=0 is ignored.
- Writes: on the rising edge, each enabled port with a nonzero address stores its data.
- Same-address write collision (`wr0_en` & `wr1_en` & equal addresses): port 1 wins and the port-0 data is lost. No error is flagged.
- Read data for port k is selected in this order:
  - address 0 gives 0;
  - otherwise, if BYPASS=1 and `wr1` hits the address, `wr1_data`;
  - otherwise, if BYPASS=1 and `wr0` hits the address, `wr0_data`;
  - otherwise the stored value.
- Scoreboard: one busy bit per register.
  - Set: `iss_en` sets `busy[iss_addr]` on the next edge.
  - Clear: an enabled write on either port clears `busy[wr*_addr]` on the next edge.
  - Set and clear of the same register in the same cycle: set wins, because the new producer supersedes the retiring one.
  - Issue to a register that is already busy: no change. The bit stays 1. This is legal (WAW).
- `rd_busy[k]` reports:
  - 0 if `rd_addr[k]`=0;
  - otherwise, if BYPASS=1 and `rd_addr[k]` matches an enabled write this cycle, 0;
  - otherwise `busy[rd_addr[k]]`.
  - Same-cycle `iss_en` never affects `rd_busy`. It becomes visible after the edge.
- When BYPASS=0, `rd_busy` is the registered bit only.

## Timing
- Reset: asynchronous assert, with de-assertion taken synchronously by the parent.
  - All registers are 0 and `busy_vec` is 0 during and after reset.
  - `rd_data`, `rd_busy` and `dbg_data` are 0 for all addresses while reset is asserted.
  - A write or issue presented in a cycle where `rst` is high is dropped.
- Read latency:
  - 0 cycles (combinational) for `rd_data` and `rd_busy`.
  - With BYPASS=0, a written value is visible the cycle after the write edge.
- Scoreboard latency: `busy_vec` reflects an issue or a clear 1 cycle after the edge at which it is presented.
- There is no handshake. All inputs are sampled every edge. Enables qualify the corresponding address and data.

## Structure
- A shared package `rf_pkg` holds:
  - the default constants `XLEN_D`, `NREGS_D`;
  - a function `rf_sel` implementing the read priority (zero / wr1 / wr0 / stored).
- One sub-module, `rf_scoreboard`, owns the `NREGS` busy flops plus their set/clear logic.
  - It is parametrised on `NREGS` and `AW`.
  - Its outputs are `busy_vec` and a combinational lookup for each read port.
- The data array and the read muxes stay in `regfile_mp`. Read ports are built with a `generate` loop over `NRD`.

## Test plan
- Reset mid-run:
  - Write 0xDEADBEEF to x5 and issue x7.
  - Assert `rst` between edges.
  - Required: `rd_data` for x5 is 0 and `busy_vec` is 0 immediately, without waiting for an edge; both remain 0 after release.
- Bypass (BYPASS=1):
  - In one cycle, `wr0` writes x3 with 0x11 and `rd_addr[0]`=3.
  - Required: `rd_data[0]`=0x11 in the same cycle.
  - Repeat with BYPASS=0. Required: the old value in that cycle, then 0x11 the following cycle.
- Write collision:
  - `wr0` writes x9 with 0xAAAA and `wr1` writes x9 with 0x5555 in the same cycle.
  - Required: the stored value is 0x5555, and a same-cycle bypass read of x9 returns 0x5555.
- x0 immunity:
  - `wr1` writes x0 with 0xFFFFFFFF and `iss_en` targets x0.
  - Required: reads and `dbg_data` of x0 return 0; `busy_vec[0]` stays 0.
- Scoreboard race:
  - x4 is busy. In one cycle, `wr0` writes x4 and `iss_en` targets x4.
  - Required: `busy_vec[4]` is 1 after the edge.
  - A following write-only cycle to x4 clears it: `busy_vec[4]`=0.
- Parameter sweep: instantiate with `XLEN`=64, `NREGS`=16, `NRD`=3. Fill every register with its index times 0x0101_0101_0101_0101 and read all of them back on all three ports plus `dbg_addr`.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants and the read-source priority for the multi-port register file.
// Sources are ranked zero, then write port 1, then write port 0, then stored data.
package rf_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_WR1,
        SEL_WR0,
        SEL_STORED
    } rf_sel_e;

    // Port 1 outranks port 0, which matches port 1 winning a same-address write.
    function automatic rf_sel_e rf_sel(
        input logic addr_zero,
        input logic hit_wr1,
        input logic hit_wr0,
        input logic bypass
    );
        if (addr_zero)
            return SEL_ZERO;
        if (bypass && hit_wr1)
            return SEL_WR1;
        if (bypass && hit_wr0)
            return SEL_WR0;
        return SEL_STORED;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp.
// The master drives addresses, writes and issues; the slave returns read data and scoreboard state.
interface regfile_mp_if import rf_pkg::*; #(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, dbg_addr,
        input  rd_data, rd_busy, dbg_data, busy_vec
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, dbg_addr,
        output rd_data, rd_busy, dbg_data, busy_vec
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy flop per register, set on issue and cleared on writeback.
// It also provides the per-read-port busy lookup.
module rf_scoreboard #(
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr0_en,
    input  logic [AW-1:0]     i_wr0_addr,
    input  logic              i_wr1_en,
    input  logic [AW-1:0]     i_wr1_addr,
    input  logic              i_iss_en,
    input  logic [AW-1:0]     i_iss_addr,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy,
    output logic [NREGS-1:0]  o_busy_vec
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // The issue is applied after the clears, so a new producer keeps the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wr0_en)
            w_busy_nxt[i_wr0_addr] = 1'b0;
        if (i_wr1_en)
            w_busy_nxt[i_wr1_addr] = 1'b0;
        if (i_iss_en)
            w_busy_nxt[i_iss_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign o_busy_vec = r_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_lookup
        logic [AW-1:0] w_addr;
        logic          w_wr_hit;
        assign w_addr   = i_rd_addr[k*AW +: AW];
        assign w_wr_hit = (BYPASS != 0) &&
                          ((i_wr0_en && (i_wr0_addr == w_addr)) ||
                           (i_wr1_en && (i_wr1_addr == w_addr)));
        assign o_rd_busy[k] = (w_addr != '0) && !w_wr_hit && r_busy[w_addr];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NRD combinational read ports, a debug port,
// and a pending-write scoreboard. x0 is hardwired to zero.
module regfile_mp import rf_pkg::*; #(
    parameter int XLEN   = XLEN_D,
    parameter int NREGS  = NREGS_D,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr0_ok;
    logic            w_wr1_ok;
    logic [XLEN-1:0] w_dbg;

    assign w_wr0_ok = bus.wr0_en && (bus.wr0_addr != '0);
    assign w_wr1_ok = bus.wr1_en && (bus.wr1_addr != '0);

    // Port 1 is written last, so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_wr0_ok)
                r_mem[bus.wr0_addr] <= bus.wr0_data;
            if (w_wr1_ok)
                r_mem[bus.wr1_addr] <= bus.wr1_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        rf_sel_e         w_sel;
        logic [XLEN-1:0] w_data;

        assign w_addr = bus.rd_addr[k*AW +: AW];
        assign w_sel  = rf_sel(w_addr == '0,
                               bus.wr1_en && (bus.wr1_addr == w_addr),
                               bus.wr0_en && (bus.wr0_addr == w_addr),
                               BYPASS != 0);

        // Reset also masks the bypass path, so every read returns 0 while rst is high.
        always_comb begin
            w_data = '0;
            if (!rst) begin
                case (w_sel)
                    SEL_WR1:    w_data = bus.wr1_data;
                    SEL_WR0:    w_data = bus.wr0_data;
                    SEL_STORED: w_data = r_mem[w_addr];
                    default:    w_data = '0;
                endcase
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = w_data;
    end

    always_comb begin
        w_dbg = '0;
        if (!rst && (bus.dbg_addr != '0))
            w_dbg = r_mem[bus.dbg_addr];
    end

    assign bus.dbg_data = w_dbg;

    rf_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_wr0_en   (bus.wr0_en),
        .i_wr0_addr (bus.wr0_addr),
        .i_wr1_en   (bus.wr1_en),
        .i_wr1_addr (bus.wr1_addr),
        .i_iss_en   (bus.iss_en),
        .i_iss_addr (bus.iss_addr),
        .i_rd_addr  (bus.rd_addr),
        .o_rd_busy  (bus.rd_busy),
        .o_busy_vec (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypass and a non-bypass 32x32 instance driven in lockstep
// against an array model, plus a 64-bit/16-entry/3-port instance for the parameter sweep.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   cmp_on = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_b ();
    regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) bus_c ();

    regfile_mp #(.BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_mp #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural model of the 32x32 file: stored values and pending-producer flags.
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
            m_busy = 32'h0;
        end else begin
            if (bus_a.wr0_en && bus_a.wr0_addr != 5'd0) m_reg[bus_a.wr0_addr] = bus_a.wr0_data;
            if (bus_a.wr1_en && bus_a.wr1_addr != 5'd0) m_reg[bus_a.wr1_addr] = bus_a.wr1_data;
            if (bus_a.wr0_en) m_busy[bus_a.wr0_addr] = 1'b0;
            if (bus_a.wr1_en) m_busy[bus_a.wr1_addr] = 1'b0;
            if (bus_a.iss_en && bus_a.iss_addr != 5'd0) m_busy[bus_a.iss_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (rst || a == 5'd0) return 32'h0;
        if (byp && bus_a.wr1_en && bus_a.wr1_addr == a) return bus_a.wr1_data;
        if (byp && bus_a.wr0_en && bus_a.wr0_addr == a) return bus_a.wr0_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (rst || a == 5'd0) return 1'b0;
        if (byp && ((bus_a.wr0_en && bus_a.wr0_addr == a) || (bus_a.wr1_en && bus_a.wr1_addr == a)))
            return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                chk("a_rd_data", 64'(bus_a.rd_data[k*32 +: 32]), 64'(exp_rd(bus_a.rd_addr[k*5 +: 5], 1'b1)));
                chk("b_rd_data", 64'(bus_b.rd_data[k*32 +: 32]), 64'(exp_rd(bus_b.rd_addr[k*5 +: 5], 1'b0)));
                chk("a_rd_busy", 64'(bus_a.rd_busy[k]), 64'(exp_busy(bus_a.rd_addr[k*5 +: 5], 1'b1)));
                chk("b_rd_busy", 64'(bus_b.rd_busy[k]), 64'(exp_busy(bus_b.rd_addr[k*5 +: 5], 1'b0)));
            end
            chk("a_dbg", 64'(bus_a.dbg_data), 64'(rst ? 32'h0 : m_reg[bus_a.dbg_addr]));
            chk("b_dbg", 64'(bus_b.dbg_data), 64'(rst ? 32'h0 : m_reg[bus_b.dbg_addr]));
            chk("a_busy_vec", 64'(bus_a.busy_vec), 64'(m_busy));
            chk("b_busy_vec", 64'(bus_b.busy_vec), 64'(m_busy));
        end
    end

    task automatic set_wr(input bit e0, input logic [4:0] a0, input logic [31:0] d0,
                          input bit e1, input logic [4:0] a1, input logic [31:0] d1,
                          input bit ie, input logic [4:0] ia);
        bus_a.wr0_en = e0; bus_a.wr0_addr = a0; bus_a.wr0_data = d0;
        bus_a.wr1_en = e1; bus_a.wr1_addr = a1; bus_a.wr1_data = d1;
        bus_a.iss_en = ie; bus_a.iss_addr = ia;
        bus_b.wr0_en = e0; bus_b.wr0_addr = a0; bus_b.wr0_data = d0;
        bus_b.wr1_en = e1; bus_b.wr1_addr = a1; bus_b.wr1_data = d1;
        bus_b.iss_en = ie; bus_b.iss_addr = ia;
    endtask

    task automatic set_rd(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dbg);
        bus_a.rd_addr = {r1, r0}; bus_a.dbg_addr = dbg;
        bus_b.rd_addr = {r1, r0}; bus_b.dbg_addr = dbg;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        bus_c.wr0_en = 1'b0;
        bus_c.wr1_en = 1'b0;
    endtask

    logic [63:0] pat;

    initial begin
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        set_rd(5'd0, 5'd0, 5'd0);
        bus_c.rd_addr = '0; bus_c.dbg_addr = '0;
        bus_c.wr0_en = 1'b0; bus_c.wr0_addr = '0; bus_c.wr0_data = '0;
        bus_c.wr1_en = 1'b0; bus_c.wr1_addr = '0; bus_c.wr1_data = '0;
        bus_c.iss_en = 1'b0; bus_c.iss_addr = '0;
        #1 rst = 1'b1;
        #1 cmp_on = 1'b1;
        chk("reset_busy_vec", 64'(bus_a.busy_vec), 64'h0);
        chk("reset_rd_data", 64'(bus_a.rd_data), 64'h0);
        cyc; cyc;
        rst = 1'b0;

        // Reset mid-run
        set_wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        cyc;
        set_rd(5'd5, 5'd7, 5'd5);
        #2;
        chk("pre_rst_x5", 64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
        chk("pre_rst_busy7", 64'(bus_a.busy_vec[7]), 64'h1);
        rst = 1'b1;
        #1;
        chk("rst_async_x5_a", 64'(bus_a.rd_data[31:0]), 64'h0);
        chk("rst_async_x5_b", 64'(bus_b.rd_data[31:0]), 64'h0);
        chk("rst_async_busy_vec", 64'(bus_a.busy_vec), 64'h0);
        chk("rst_async_dbg", 64'(bus_a.dbg_data), 64'h0);
        cyc;
        rst = 1'b0;
        #2;
        chk("post_rst_x5", 64'(bus_a.rd_data[31:0]), 64'h0);
        chk("post_rst_busy_vec", 64'(bus_a.busy_vec), 64'h0);

        // Bypass vs stored-only read of x3
        cyc;
        set_rd(5'd3, 5'd0, 5'd3);
        set_wr(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #2;
        chk("bypass_same_cycle", 64'(bus_a.rd_data[31:0]), 64'h11);
        chk("nobypass_old_value", 64'(bus_b.rd_data[31:0]), 64'h0);
        cyc;
        #2;
        chk("nobypass_next_cycle", 64'(bus_b.rd_data[31:0]), 64'h11);

        // Write collision on x9
        set_rd(5'd0, 5'd9, 5'd9);
        set_wr(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 32'h5555, 1'b0, 5'd0);
        #2;
        chk("collision_bypass", 64'(bus_a.rd_data[63:32]), 64'h5555);
        cyc;
        #2;
        chk("collision_stored", 64'(bus_b.rd_data[63:32]), 64'h5555);
        chk("collision_dbg", 64'(bus_a.dbg_data), 64'h5555);

        // x0 immunity
        set_rd(5'd0, 5'd0, 5'd0);
        set_wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
        #2;
        chk("x0_bypass_read", 64'(bus_a.rd_data[31:0]), 64'h0);
        cyc;
        #2;
        chk("x0_read", 64'(bus_a.rd_data[31:0]), 64'h0);
        chk("x0_dbg", 64'(bus_a.dbg_data), 64'h0);
        chk("x0_busy", 64'(bus_a.busy_vec[0]), 64'h0);

        // Scoreboard race on x4
        set_rd(5'd4, 5'd0, 5'd4);
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        cyc;
        #2;
        chk("x4_busy_set", 64'(bus_a.busy_vec[4]), 64'h1);
        chk("x4_rd_busy", 64'(bus_a.rd_busy[0]), 64'h1);
        set_wr(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        #1;
        chk("x4_rd_busy_bypass", 64'(bus_a.rd_busy[0]), 64'h0);
        chk("x4_rd_busy_nobypass", 64'(bus_b.rd_busy[0]), 64'h1);
        cyc;
        #2;
        chk("x4_race_set_wins", 64'(bus_a.busy_vec[4]), 64'h1);
        set_wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0);
        cyc;
        #2;
        chk("x4_cleared", 64'(bus_a.busy_vec[4]), 64'h0);
        chk("x4_value", 64'(bus_a.dbg_data), 64'h45);

        // Mixed directed traffic, checked cycle by cycle against the model
        for (int n = 0; n < 24; n++) begin
            set_wr(n % 3 != 0, 5'(n * 7 + 1), 32'(n) * 32'h01010101 + 32'd3,
                   n % 2 == 0, 5'(n * 3 + 2), 32'hC000_0000 | 32'(n),
                   n % 4 == 1, 5'(n * 5));
            set_rd(5'(n * 7 + 1), 5'(n * 3), 5'(n * 11));
            cyc;
        end

        // Parameter sweep on the 64-bit, 16-entry, 3-port instance
        for (int i = 1; i < 16; i += 2) begin
            bus_c.wr0_en = 1'b1; bus_c.wr0_addr = 4'(i);
            bus_c.wr0_data = 64'(i) * 64'h0101010101010101;
            bus_c.wr1_en = (i + 1 < 16); bus_c.wr1_addr = 4'(i + 1);
            bus_c.wr1_data = 64'(i + 1) * 64'h0101010101010101;
            cyc;
        end
        for (int i = 0; i < 16; i++) begin
            bus_c.rd_addr = {4'((i + 11) % 16), 4'((i + 5) % 16), 4'(i)};
            bus_c.dbg_addr = 4'(i);
            #2;
            pat = 64'(i) * 64'h0101010101010101;
            chk("sweep_port0", bus_c.rd_data[63:0], pat);
            pat = 64'((i + 5) % 16) * 64'h0101010101010101;
            chk("sweep_port1", bus_c.rd_data[127:64], pat);
            pat = 64'((i + 11) % 16) * 64'h0101010101010101;
            chk("sweep_port2", bus_c.rd_data[191:128], pat);
            pat = 64'(i) * 64'h0101010101010101;
            chk("sweep_dbg", bus_c.dbg_data, pat);
            cyc;
        end

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
